// File: rtl/shift_engine_if.sv
// Op-issue / result bundle between a control FSM (master) and shift_engine (slave).
// WIDTH and SHW must match the parameters of the shift_engine instance bound to it.
interface shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic [2:0]       op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] d_in;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] d_out;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output op, shamt, d_in, op_valid,
    input  op_ready, d_out, carry, zero, busy, done
  );

  modport slave (
    input  op, shamt, d_in, op_valid,
    output op_ready, d_out, carry, zero, busy, done
  );
endinterface

// File: rtl/shift_engine.sv
// Multi-cycle WIDTH-bit shift/rotate engine, at most STEP bits per cycle.
// Single-cycle ops and zero-amount shifts complete on the accepting edge.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3,
  parameter int STEP  = 1
) (
  input logic          clk,
  input logic          reset_n,
  shift_engine_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_r, state_n;
  op_e              op_r, op_n, op_in;
  logic [SHW-1:0]   rem_r, rem_n, rem_after;
  logic [WIDTH-1:0] data_r, data_n, step_d;
  logic             carry_r, carry_n, step_c;
  logic             done_r, done_n;

  assign op_in = op_e'(bus.op);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      op_r    <= OP_NOP;
      rem_r   <= {SHW{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      op_r    <= op_n;
      rem_r   <= rem_n;
      data_r  <= data_n;
      carry_r <= carry_n;
      done_r  <= done_n;
    end
  end

  // Next-state, step datapath and acceptance decode
  always_comb begin
    state_n = state_r;
    op_n    = op_r;
    rem_n   = rem_r;
    data_n  = data_r;
    carry_n = carry_r;
    done_n  = 1'b0;
    step_d  = data_r;
    step_c  = carry_r;

    // One-bit moves chained STEP times; only the first min(rem, STEP) take effect.
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(rem_r)) begin
        case (op_r)
          OP_LSL: begin
            step_c = step_d[WIDTH-1];
            step_d = {step_d[WIDTH-2:0], 1'b0};
          end
          OP_LSR: begin
            step_c = step_d[0];
            step_d = {1'b0, step_d[WIDTH-1:1]};
          end
          OP_ASR: begin
            step_c = step_d[0];
            step_d = {step_d[WIDTH-1], step_d[WIDTH-1:1]};
          end
          OP_ROL: begin
            step_c = step_d[WIDTH-1];
            step_d = {step_d[WIDTH-2:0], step_d[WIDTH-1]};
          end
          OP_ROR: begin
            step_c = step_d[0];
            step_d = {step_d[0], step_d[WIDTH-1:1]};
          end
          default: begin
            step_c = step_c;
            step_d = step_d;
          end
        endcase
      end else begin
        step_d = step_d;
      end
    end

    if (int'(rem_r) > STEP) begin
      rem_after = rem_r - SHW'(STEP);
    end else begin
      rem_after = {SHW{1'b0}};
    end

    case (state_r)
      IDLE: begin
        if (bus.op_valid) begin
          case (op_in)
            OP_NOP: begin
              done_n = 1'b1;
            end
            OP_LOAD: begin
              data_n  = bus.d_in;
              carry_n = 1'b0;
              done_n  = 1'b1;
            end
            OP_CLR: begin
              data_n  = {WIDTH{1'b0}};
              carry_n = 1'b0;
              done_n  = 1'b1;
            end
            default: begin
              if (bus.shamt == {SHW{1'b0}}) begin
                carry_n = 1'b0;
                done_n  = 1'b1;
              end else begin
                op_n    = op_in;
                rem_n   = bus.shamt;
                state_n = SHIFT;
              end
            end
          endcase
        end else begin
          done_n = 1'b0;
        end
      end
      SHIFT: begin
        data_n  = step_d;
        carry_n = step_c;
        rem_n   = rem_after;
        if (rem_after == {SHW{1'b0}}) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = SHIFT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_r == SHIFT);
  assign bus.op_ready = (state_r == IDLE);
  assign bus.d_out    = data_r;
  assign bus.carry    = carry_r;
  assign bus.zero     = (data_r == {WIDTH{1'b0}});
  assign bus.done     = done_r;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed scenarios plus random ops
// compared against an arithmetic reference model of the register and latency.
module tb_shift_engine;
  localparam int W    = 8;
  localparam int SHW  = 4;
  localparam int STEP = 2;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] LSL  = 3'd2;
  localparam logic [2:0] LSR  = 3'd3;
  localparam logic [2:0] ASR  = 3'd4;
  localparam logic [2:0] ROL  = 3'd5;
  localparam logic [2:0] ROR  = 3'd6;
  localparam logic [2:0] CLR  = 3'd7;

  logic clk;
  logic reset_n;
  int   tests;
  int   fails;

  logic [W-1:0] m_d;
  logic         m_c;

  shift_engine_if #(.WIDTH(W), .SHW(SHW)) bus ();

  shift_engine #(.WIDTH(W), .SHW(SHW), .STEP(STEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Result of one op computed from the shift definitions, returned as {d, carry}.
  function automatic logic [W:0] model(input logic [2:0] o, input int sh,
                                       input logic [W-1:0] din,
                                       input logic [W-1:0] d, input logic c);
    logic [63:0]    v;
    logic [63:0]    sv;
    logic [2*W-1:0] dd;
    logic [W-1:0]   nd;
    logic           nc;
    int             r;
    nd = d;
    nc = c;
    dd = {d, d};
    r  = sh % W;
    v  = 64'(d);
    sv = {{(64-W){d[W-1]}}, d};
    case (o)
      LOAD: begin nd = din; nc = 1'b0; end
      CLR:  begin nd = '0;  nc = 1'b0; end
      LSL: begin
        v  = 64'(d) << sh;
        nd = v[W-1:0];
        nc = (sh == 0) ? 1'b0 : v[W];
      end
      LSR: begin
        nd = W'(v >> sh);
        nc = (sh == 0) ? 1'b0 : v[sh-1];
      end
      ASR: begin
        nd = W'(sv >> sh);
        nc = (sh == 0) ? 1'b0 : sv[sh-1];
      end
      ROL: begin
        v  = 64'(dd) << r;
        nd = v[2*W-1:W];
        nc = (sh == 0) ? 1'b0 : nd[0];
      end
      ROR: begin
        v  = 64'(dd) >> r;
        nd = v[W-1:0];
        nc = (sh == 0) ? 1'b0 : nd[W-1];
      end
      default: begin nd = d; nc = c; end
    endcase
    return {nd, nc};
  endfunction

  function automatic int latency(input logic [2:0] o, input int sh);
    if (o == NOP || o == LOAD || o == CLR || sh == 0) return 0;
    return (sh + STEP - 1) / STEP;
  endfunction

  // Issue one op now (inputs set between edges), follow it to completion and check it.
  // With spam set, a LOAD 0x00 request is held while busy and must be ignored.
  task automatic run_op(input logic [2:0] o, input int sh, input logic [W-1:0] din,
                        input bit spam, input string tag);
    logic [W:0]   e;
    logic [W-1:0] ed;
    logic         ec;
    int           n;
    e  = model(o, sh, din, m_d, m_c);
    ed = e[W:1];
    ec = e[0];
    n  = latency(o, sh);
    bus.op       = o;
    bus.shamt    = SHW'(sh);
    bus.d_in     = din;
    bus.op_valid = 1'b1;
    chk({tag, "_ready"}, 32'(bus.op_ready), 32'(1'b1));
    @(posedge clk); #1;
    bus.op       = LOAD;
    bus.d_in     = '0;
    bus.op_valid = spam;
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'(1'b1));
      chk({tag, "_nodone"}, 32'(bus.done), 32'(1'b0));
      chk({tag, "_notready"}, 32'(bus.op_ready), 32'(1'b0));
      if (i == n) bus.op_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.op_valid = 1'b0;
    chk({tag, "_done"}, 32'(bus.done), 32'(1'b1));
    chk({tag, "_idle"}, 32'(bus.busy), 32'(1'b0));
    chk({tag, "_d"}, 32'(bus.d_out), 32'(ed));
    chk({tag, "_c"}, 32'(bus.carry), 32'(ec));
    chk({tag, "_z"}, 32'(bus.zero), 32'(ed == '0));
    m_d = ed;
    m_c = ec;
  endtask

  task automatic idle_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, 32'(bus.done), 32'(1'b0));
    chk({tag, "_hold"}, 32'(bus.d_out), 32'(m_d));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_d = '0;
    m_c = 1'b0;
    reset_n      = 1'b0;
    bus.op       = NOP;
    bus.shamt    = '0;
    bus.d_in     = '0;
    bus.op_valid = 1'b0;
    #1;
    chk("rst_d", 32'(bus.d_out), 32'h0);
    chk("rst_z", 32'(bus.zero), 32'(1'b1));
    chk("rst_busy", 32'(bus.busy), 32'(1'b0));
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    run_op(LOAD, 0, 8'hB4, 1'b0, "ld_b4");
    bus.op = LSL; bus.shamt = 4'd3; bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    chk("lsl3_mid_d", 32'(bus.d_out), 32'hD0);
    chk("lsl3_mid_c", 32'(bus.carry), 32'(1'b0));
    @(posedge clk); #1;
    chk("lsl3_d", 32'(bus.d_out), 32'hA0);
    chk("lsl3_c", 32'(bus.carry), 32'(1'b1));
    chk("lsl3_done", 32'(bus.done), 32'(1'b1));
    chk("lsl3_busy", 32'(bus.busy), 32'(1'b0));
    m_d = 8'hA0; m_c = 1'b1;
    idle_chk("lsl3_pulse");

    run_op(LOAD, 0, 8'h96, 1'b0, "ld_96");
    run_op(ASR, 3, 8'h00, 1'b1, "asr3");
    chk("asr3_lit", 32'(bus.d_out), 32'hF2);
    run_op(LOAD, 0, 8'h81, 1'b0, "ld_81");
    run_op(ROR, 9, 8'h00, 1'b0, "ror9");
    chk("ror9_lit", 32'(bus.d_out), 32'hC0);
    run_op(ROL, 8, 8'h00, 1'b1, "rol8");
    chk("rol8_lit", 32'(bus.d_out), 32'hC0);
    run_op(LOAD, 0, 8'h01, 1'b0, "ld_01");
    run_op(LSR, 0, 8'h00, 1'b0, "lsr0");
    run_op(LSR, 1, 8'h00, 1'b0, "lsr1_b2b");
    chk("lsr1_z_lit", 32'(bus.zero), 32'(1'b1));
    run_op(LOAD, 0, 8'h5A, 1'b0, "seq_ld");
    run_op(CLR, 0, 8'hFF, 1'b0, "seq_clr");
    run_op(NOP, 0, 8'hFF, 1'b0, "seq_nop");
    idle_chk("seq_end");
    run_op(LOAD, 0, 8'hA5, 1'b0, "ld_a5");
    run_op(LSL, 9, 8'h00, 1'b0, "lsl9");
    run_op(LOAD, 0, 8'hA5, 1'b0, "ld_a5b");
    run_op(LSR, 8, 8'h00, 1'b0, "lsr8");
    run_op(LOAD, 0, 8'h80, 1'b0, "ld_80");
    run_op(ASR, 15, 8'h00, 1'b0, "asr15");

    // Reset in the middle of a shift
    run_op(LOAD, 0, 8'hFF, 1'b0, "ld_ff");
    bus.op = LSL; bus.shamt = 4'd8; bus.op_valid = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_d", 32'(bus.d_out), 32'h0);
    chk("mrst_c", 32'(bus.carry), 32'(1'b0));
    chk("mrst_z", 32'(bus.zero), 32'(1'b1));
    chk("mrst_busy", 32'(bus.busy), 32'(1'b0));
    chk("mrst_done", 32'(bus.done), 32'(1'b0));
    @(posedge clk); #2;
    reset_n = 1'b1;
    m_d = '0; m_c = 1'b0;
    chk("mrst_ready", 32'(bus.op_ready), 32'(1'b1));
    idle_chk("mrst_a");
    idle_chk("mrst_b");

    // Random ops against the model
    for (int k = 0; k < 60; k++) begin
      logic [2:0] o;
      int         sh;
      logic [W-1:0] din;
      bit         spam;
      o    = 3'($urandom_range(0, 7));
      sh   = int'($urandom_range(0, 15));
      din  = W'($urandom);
      spam = 1'($urandom_range(0, 1));
      run_op(o, sh, din, spam, "rnd");
      if ($urandom_range(0, 3) == 0) idle_chk("rnd_gap");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
